// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding,
// the RV32 NOP used as the ID-stage bubble, and the default counter width.
package pipe_pkg;

    localparam logic [31:0] RV32_NOP  = 32'h0000_0013;
    localparam int          CNT_W_DEF = 16;

    // The state encoding equals the number of held entries, so occupancy is the state itself.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = S_EMPTY,
        ONE   = S_ONE,
        TWO   = S_TWO
    } pipe_state_e;

    function automatic logic [1:0] entries_of(input logic [1:0] st);
        return (st == S_TWO) ? 2'd2 : (st == S_ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between two pipe stages.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous active-low clear; adds 0..2 per cycle
// and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready payload stage with stall hold,
// flush-to-bubble, optional skid entry for a registered up_ready, and perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SKID       = 1'b1,
    parameter int                CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_data;
    logic              skid_ld;
    logic              up_xfer, dn_xfer;

    assign up_xfer   = up.valid & up.ready;
    assign dn_xfer   = dn.valid & dn.ready;
    assign dn.valid  = (state_q != S_EMPTY) & ~stall;
    assign dn.data   = main_q;
    assign occupancy = entries_of(state_q);

    // Stall needs no explicit term here: it already blocks both handshakes.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_ld = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                S_EMPTY: if (up_xfer) begin
                    state_d = S_ONE;
                    main_d  = up.data;
                end
                S_ONE: case ({up_xfer, dn_xfer})
                    2'b11: main_d = up.data;
                    2'b10: if (SKID) begin
                        state_d = S_TWO;
                        skid_ld = 1'b1;
                    end
                    2'b01: begin
                        state_d = S_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                    default: ;
                endcase
                S_TWO: if (dn_xfer) begin
                    state_d = S_ONE;
                    main_d  = skid_data;
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    if (SKID) begin : g_skid
        logic [DATA_W-1:0] skid_q;
        logic              full_q;

        // full_q mirrors state==TWO as its own flop so up_ready has no path from dn_ready.
        always_ff @(posedge clk) begin
            if (!rst) begin
                skid_q <= BUBBLE_VAL;
                full_q <= 1'b0;
            end else begin
                full_q <= (state_d == S_TWO);
                if (flush)                          skid_q <= BUBBLE_VAL;
                else if (skid_ld)                   skid_q <= up.data;
                else if (state_q == S_TWO && dn_xfer) skid_q <= BUBBLE_VAL;
            end
        end

        assign skid_data = skid_q;
        assign up.ready  = ~full_q & ~stall;
    end else begin : g_noskid
        assign skid_data = BUBBLE_VAL;
        assign up.ready  = ((state_q == S_EMPTY) | dn.ready) & ~stall;
    end

    logic [1:0] flush_inc;
    assign flush_inc = flush ? entries_of(state_q) : 2'd0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i ({1'b0, stall}),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1/CNT_W=4 stage and a SKID=0/CNT_W=16 stage with identical stimulus;
// each has a FIFO scoreboard plus counter model checked every cycle on the falling edge.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int             DW  = 64;
    localparam logic [DW-1:0]  BUB = {32'h0, RV32_NOP};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uv  = 1'b1;
    logic          dr  = 1'b1;
    logic          st  = 1'b0;
    logic          fl  = 1'b0;
    logic [DW-1:0] ud  = 64'hDEAD_BEEF_0000_0001;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit          SK   = (g == 0);
        localparam int          CW   = (g == 0) ? 4 : 16;
        localparam logic [63:0] CMAX = (64'd1 << CW) - 64'd1;

        pipe_stage_reg_if #(.DATA_W(DW)) up_if ();
        pipe_stage_reg_if #(.DATA_W(DW)) dn_if ();
        logic [1:0]    occ;
        logic [CW-1:0] sc, fc;

        assign up_if.valid = uv;
        assign up_if.data  = ud;
        assign dn_if.ready = dr;

        pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID(SK), .CNT_W(CW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .up        (up_if),
            .dn        (dn_if),
            .stall     (st),
            .flush     (fl),
            .occupancy (occ),
            .stall_cnt (sc),
            .flush_cnt (fc)
        );

        logic [63:0] q[$];
        logic [63:0] exp_sc = 0;
        logic [63:0] exp_fc = 0;
        logic        exp_ur, exp_dv;

        always @(negedge clk) begin
            if (!rst) begin
                q.delete();
                exp_sc = 0;
                exp_fc = 0;
            end else begin
                exp_dv = (q.size() != 0) && !st;
                exp_ur = (SK ? (q.size() < 2) : (q.size() == 0 || dr)) && !st;
                chk($sformatf("d%0d_occupancy", g), 64'(occ), 64'(q.size()));
                chk($sformatf("d%0d_up_ready", g), 64'(up_if.ready), 64'(exp_ur));
                chk($sformatf("d%0d_dn_valid", g), 64'(dn_if.valid), 64'(exp_dv));
                chk($sformatf("d%0d_dn_data", g), dn_if.data, (q.size() != 0) ? q[0] : BUB);
                chk($sformatf("d%0d_stall_cnt", g), 64'(sc), exp_sc);
                chk($sformatf("d%0d_flush_cnt", g), 64'(fc), exp_fc);
                if (fl) begin
                    exp_fc = exp_fc + 64'(q.size());
                    if (exp_fc > CMAX) exp_fc = CMAX;
                    q.delete();
                end else begin
                    if (exp_dv && dr) void'(q.pop_front());
                    if (exp_ur && uv) q.push_back(ud);
                end
                if (st && exp_sc < CMAX) exp_sc = exp_sc + 64'd1;
            end
        end
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                       input logic s, input logic f);
        @(posedge clk);
        #1;
        uv = v; ud = d; dr = r; st = s; fl = f;
    endtask

    initial begin
        // Reset held 3 clocks while upstream offers data.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d0_dn_valid", 64'(g_dut[0].dn_if.valid), 64'd0);
        chk("rst_d0_dn_data",  g_dut[0].dn_if.data, BUB);
        chk("rst_d0_occ",      64'(g_dut[0].occ), 64'd0);
        chk("rst_d0_cnts",     {g_dut[0].sc, g_dut[0].fc}, 64'd0);
        chk("rst_d1_dn_valid", 64'(g_dut[1].dn_if.valid), 64'd0);
        chk("rst_d1_dn_data",  g_dut[1].dn_if.data, BUB);
        chk("rst_d1_occ",      64'(g_dut[1].occ), 64'd0);
        chk("rst_d1_cnts",     {g_dut[1].sc, g_dut[1].fc}, 64'd0);
        rst = 1'b1; uv = 1'b0;

        // Back-to-back streaming 1..8.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A then B with dn_ready low, then release.
        cyc(1'b1, 64'hAAAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hBBBB, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 64'd0,    1'b0, 1'b0, 1'b0);
        #3;
        chk("bp_d0_occ",      64'(g_dut[0].occ), 64'd2);
        chk("bp_d0_up_ready", 64'(g_dut[0].up_if.ready), 64'd0);
        repeat (3) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Stall 5 cycles while holding a valid payload.
        cyc(1'b1, 64'h5555, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        #3;
        chk("stall_d0_cnt", 64'(g_dut[0].sc), 64'd5);
        chk("stall_d1_cnt", 64'(g_dut[1].sc), 64'd5);
        repeat (2) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Flush a full stage while C is offered in the same cycle.
        cyc(1'b1, 64'hA2A2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hB2B2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hCCCC, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'd0,    1'b1, 1'b0, 1'b0);
        #3;
        chk("flush_d0_cnt",   64'(g_dut[0].fc), 64'd2);
        chk("flush_d1_cnt",   64'(g_dut[1].fc), 64'd1);
        chk("flush_d0_data",  g_dut[0].dn_if.data, BUB);
        chk("flush_d0_occ",   64'(g_dut[0].occ), 64'd0);
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Stall saturation on the 4-bit counter.
        repeat (20) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        #3;
        chk("sat_d0_stall_cnt", 64'(g_dut[0].sc), 64'd15);
        chk("sat_d1_stall_cnt", 64'(g_dut[1].sc), 64'd25);
        repeat (3) cyc(1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 19) == 0));

        // Reset mid-traffic drops in-flight payload and clears counters.
        cyc(1'b1, 64'h7777, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1; rst = 1'b0; uv = 1'b1; ud = 64'h8888;
        @(posedge clk); #1; rst = 1'b1; uv = 1'b0;
        #3;
        chk("midrst_d0_occ", 64'(g_dut[0].occ), 64'd0);
        chk("midrst_d0_cnt", {g_dut[0].sc, g_dut[0].fc}, 64'd0);
        repeat (4) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("drain_d0", 64'(g_dut[0].q.size()), 64'd0);
        chk("drain_d1", 64'(g_dut[1].q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
